// File: rtl/spi_bridge_pkg.sv
// Shared definitions for the SPI packet <-> FIR sample bridge.
package spi_bridge_pkg;

    localparam int SAMPLE_WIDTH_DEF       = 16;
    localparam int SAMPLES_PER_PACKET_DEF = 4;

    typedef enum logic {
        IDLE = 1'b0,
        EMIT = 1'b1
    } ingress_state_e;

    function automatic int packet_width(input int sample_width, input int samples_per_packet);
        return sample_width * samples_per_packet;
    endfunction

endpackage

// File: rtl/result_packer.sv
// Egress collector: gathers FIR results into a response packet and publishes it atomically.
module result_packer
    import spi_bridge_pkg::*;
#(
    parameter int SAMPLE_WIDTH       = SAMPLE_WIDTH_DEF,
    parameter int SAMPLES_PER_PACKET = SAMPLES_PER_PACKET_DEF,
    localparam int PACKET_WIDTH      = packet_width(SAMPLE_WIDTH, SAMPLES_PER_PACKET)
) (
    input  logic                    clkIn,
    input  logic                    nResetIn,
    input  logic [SAMPLE_WIDTH-1:0] resultIn,
    input  logic                    resultValidIn,
    output logic [PACKET_WIDTH-1:0] packetOut,
    output logic                    packetUpdatedOut
);

    localparam int CW = $clog2(SAMPLES_PER_PACKET);

    logic [PACKET_WIDTH-1:0] coll_q, coll_d;
    logic [PACKET_WIDTH-1:0] pkt_q, pkt_d;
    logic [CW-1:0]           cnt_q, cnt_d;
    logic                    upd_q, upd_d;

    always_comb begin
        coll_d = coll_q;
        pkt_d  = pkt_q;
        cnt_d  = cnt_q;
        upd_d  = 1'b0;
        if (resultValidIn) begin
            // Newest result enters at the LSB end, so the first one ends up in the MSBs.
            coll_d = {coll_q[PACKET_WIDTH-SAMPLE_WIDTH-1:0], resultIn};
            if (cnt_q == CW'(SAMPLES_PER_PACKET - 1)) begin
                pkt_d = coll_d;
                cnt_d = '0;
                upd_d = 1'b1;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clkIn or negedge nResetIn) begin
        if (!nResetIn) begin
            coll_q <= '0;
            pkt_q  <= '0;
            cnt_q  <= '0;
            upd_q  <= 1'b0;
        end else begin
            coll_q <= coll_d;
            pkt_q  <= pkt_d;
            cnt_q  <= cnt_d;
            upd_q  <= upd_d;
        end
    end

    assign packetOut        = pkt_q;
    assign packetUpdatedOut = upd_q;

endmodule

// File: rtl/spi_sample_bridge.sv
// Unpacks SPI packets into FIR samples (MSB lane first) and packs FIR results into the reply packet.
module spi_sample_bridge
    import spi_bridge_pkg::*;
#(
    parameter int SAMPLE_WIDTH       = SAMPLE_WIDTH_DEF,
    parameter int SAMPLES_PER_PACKET = SAMPLES_PER_PACKET_DEF,
    localparam int PACKET_WIDTH      = packet_width(SAMPLE_WIDTH, SAMPLES_PER_PACKET)
) (
    input  logic                    clkIn,
    input  logic                    nResetIn,
    input  logic [PACKET_WIDTH-1:0] packetIn,
    input  logic                    packetValidIn,
    output logic [SAMPLE_WIDTH-1:0] sampleOut,
    output logic                    sampleValidOut,
    input  logic                    sampleReadyIn,
    input  logic [SAMPLE_WIDTH-1:0] resultIn,
    input  logic                    resultValidIn,
    output logic [PACKET_WIDTH-1:0] packetOut,
    output logic                    packetUpdatedOut,
    output logic                    overflowOut,
    input  logic                    clearOverflowIn
);

    localparam int IW = $clog2(SAMPLES_PER_PACKET);

    // Sample handshake: a sample transfers on any cycle where sampleValidOut & sampleReadyIn;
    // sampleOut/sampleValidOut hold stable until that happens.
    ingress_state_e          state_q, state_d;
    logic [PACKET_WIDTH-1:0] shift_q, shift_d;
    logic [IW-1:0]           idx_q, idx_d;
    logic                    ovf_q, ovf_d;
    logic                    handshake;
    logic                    last_handshake;
    logic                    ovf_set;

    always_comb begin
        state_d        = state_q;
        shift_d        = shift_q;
        idx_d          = idx_q;
        ovf_set        = 1'b0;
        handshake      = (state_q == EMIT) && sampleReadyIn;
        last_handshake = handshake && (idx_q == IW'(SAMPLES_PER_PACKET - 1));
        case (state_q)
            IDLE: begin
                if (packetValidIn) begin
                    shift_d = packetIn;
                    idx_d   = '0;
                    state_d = EMIT;
                end
            end
            EMIT: begin
                if (last_handshake) begin
                    // A packet landing on the final handshake chains straight on.
                    if (packetValidIn) begin
                        shift_d = packetIn;
                        idx_d   = '0;
                    end else begin
                        shift_d = shift_q << SAMPLE_WIDTH;
                        idx_d   = '0;
                        state_d = IDLE;
                    end
                end else begin
                    ovf_set = packetValidIn;
                    if (handshake) begin
                        shift_d = shift_q << SAMPLE_WIDTH;
                        idx_d   = idx_q + 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
        if (ovf_set) begin
            ovf_d = 1'b1;
        end else if (clearOverflowIn) begin
            ovf_d = 1'b0;
        end else begin
            ovf_d = ovf_q;
        end
    end

    always_ff @(posedge clkIn or negedge nResetIn) begin
        if (!nResetIn) begin
            state_q <= IDLE;
            shift_q <= '0;
            idx_q   <= '0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            shift_q <= shift_d;
            idx_q   <= idx_d;
            ovf_q   <= ovf_d;
        end
    end

    assign sampleOut      = shift_q[PACKET_WIDTH-1 -: SAMPLE_WIDTH];
    assign sampleValidOut = (state_q == EMIT);
    assign overflowOut    = ovf_q;

    result_packer #(
        .SAMPLE_WIDTH      (SAMPLE_WIDTH),
        .SAMPLES_PER_PACKET(SAMPLES_PER_PACKET)
    ) u_result_packer (
        .clkIn           (clkIn),
        .nResetIn        (nResetIn),
        .resultIn        (resultIn),
        .resultValidIn   (resultValidIn),
        .packetOut       (packetOut),
        .packetUpdatedOut(packetUpdatedOut)
    );

endmodule

// File: tb/tb_spi_sample_bridge.sv
// Bench for spi_sample_bridge: directed scenarios plus random traffic against a queue-based model.
module tb_spi_sample_bridge;

  localparam int SW  = 16;
  localparam int SPP = 4;
  localparam int PW  = SW * SPP;

  logic          clkIn = 1'b0;
  logic          nResetIn;
  logic [PW-1:0] packetIn;
  logic          packetValidIn;
  logic [SW-1:0] sampleOut;
  logic          sampleValidOut;
  logic          sampleReadyIn;
  logic [SW-1:0] resultIn;
  logic          resultValidIn;
  logic [PW-1:0] packetOut;
  logic          packetUpdatedOut;
  logic          overflowOut;
  logic          clearOverflowIn;

  spi_sample_bridge dut (
    .clkIn           (clkIn),
    .nResetIn        (nResetIn),
    .packetIn        (packetIn),
    .packetValidIn   (packetValidIn),
    .sampleOut       (sampleOut),
    .sampleValidOut  (sampleValidOut),
    .sampleReadyIn   (sampleReadyIn),
    .resultIn        (resultIn),
    .resultValidIn   (resultValidIn),
    .packetOut       (packetOut),
    .packetUpdatedOut(packetUpdatedOut),
    .overflowOut     (overflowOut),
    .clearOverflowIn (clearOverflowIn)
  );

  // ---------------- clock / reset ----------------
  always #5 clkIn = ~clkIn;

  // ---------------- scoreboard / reference model ----------------
  int total = 0;
  int bad   = 0;

  logic [SW-1:0] exp_q[$];   // samples still owed to the FIR, in order
  logic [SW-1:0] res_q[$];   // results gathered toward the next reply packet
  logic          m_ovf;
  logic [PW-1:0] m_pkt;
  logic          m_upd;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    exp_q.delete();
    res_q.delete();
    m_ovf = 1'b0;
    m_pkt = '0;
    m_upd = 1'b0;
  endtask

  task automatic check_outputs();
    check("valid", 64'(sampleValidOut), 64'(exp_q.size() != 0));
    if (exp_q.size() != 0) check("sample", 64'(sampleOut), 64'(exp_q[0]));
    check("overflow", 64'(overflowOut), 64'(m_ovf));
    check("packet_out", packetOut, m_pkt);
    check("updated", 64'(packetUpdatedOut), 64'(m_upd));
  endtask

  // ---------------- driver ----------------
  // Called at a negedge: checks outputs of the last edge, drives inputs, advances the model.
  task automatic step(input logic pv, input logic [PW-1:0] pkt, input logic rdy,
                      input logic rv, input logic [SW-1:0] res, input logic clr);
    logic          set;
    logic [PW-1:0] acc;
    check_outputs();
    packetValidIn   = pv;
    packetIn        = pkt;
    sampleReadyIn   = rdy;
    resultValidIn   = rv;
    resultIn        = res;
    clearOverflowIn = clr;
    if (exp_q.size() != 0 && rdy) void'(exp_q.pop_front());
    set = pv && (exp_q.size() != 0);
    if (pv && !set) begin
      for (int i = SPP - 1; i >= 0; i--) exp_q.push_back(pkt[i*SW +: SW]);
    end
    if (set) m_ovf = 1'b1;
    else if (clr) m_ovf = 1'b0;
    m_upd = 1'b0;
    if (rv) begin
      res_q.push_back(res);
      if (res_q.size() == SPP) begin
        acc = '0;
        foreach (res_q[i]) acc = (acc << SW) | PW'(res_q[i]);
        m_pkt = acc;
        m_upd = 1'b1;
        res_q.delete();
      end
    end
    @(negedge clkIn);
  endtask

  task automatic idle(input int n, input logic rdy);
    for (int i = 0; i < n; i++) step(1'b0, '0, rdy, 1'b0, '0, 1'b0);
  endtask

  task automatic send(input logic [PW-1:0] pkt, input logic rdy);
    step(1'b1, pkt, rdy, 1'b0, '0, 1'b0);
  endtask

  task automatic result(input logic [SW-1:0] r);
    step(1'b0, '0, 1'b0, 1'b1, r, 1'b0);
  endtask

  task automatic reset_mid();
    packetValidIn   = 1'b0;
    sampleReadyIn   = 1'b0;
    resultValidIn   = 1'b0;
    clearOverflowIn = 1'b0;
    #2 nResetIn = 1'b0;
    #1;
    model_reset();
    check_outputs();
    check("rst_sample", 64'(sampleOut), 64'h0);
    @(negedge clkIn);
    nResetIn = 1'b1;
  endtask

  // ---------------- stimulus ----------------
  logic [1:0] rdy_pat[7] = '{2'd1, 2'd0, 2'd0, 2'd1, 2'd1, 2'd0, 2'd1};

  initial begin
    nResetIn        = 1'b0;
    packetIn        = '0;
    packetValidIn   = 1'b0;
    sampleReadyIn   = 1'b0;
    resultIn        = '0;
    resultValidIn   = 1'b0;
    clearOverflowIn = 1'b0;
    model_reset();
    repeat (2) @(negedge clkIn);
    check_outputs();
    check("rst_sample", 64'(sampleOut), 64'h0);
    nResetIn = 1'b1;

    // unpack order
    send(64'h1111_2222_3333_4444, 1'b1);
    idle(6, 1'b1);

    // back-pressure
    send(64'hAAAA_BBBB_CCCC_DDDD, 1'b0);
    foreach (rdy_pat[i]) step(1'b0, '0, rdy_pat[i][0], 1'b0, '0, 1'b0);
    idle(3, 1'b1);

    // overflow, then set and clear in the same cycle
    send(64'h1234_5678_9ABC_DEF0, 1'b1);
    idle(1, 1'b1);
    send(64'h5555_6666_7777_8888, 1'b0);
    idle(5, 1'b1);
    send(64'h0F0F_1E1E_2D2D_3C3C, 1'b0);
    idle(1, 1'b0);
    step(1'b1, 64'h9999_9999_9999_9999, 1'b0, 1'b0, '0, 1'b1);
    idle(5, 1'b1);
    step(1'b0, '0, 1'b0, 1'b0, '0, 1'b1);
    idle(1, 1'b0);

    // back-to-back packets
    send(64'hDEAD_BEEF_CAFE_F00D, 1'b1);
    idle(3, 1'b1);
    send(64'h0001_0002_0003_0004, 1'b1);
    idle(6, 1'b1);

    // egress with gaps, then a partial collection
    result(16'h00A1);
    idle(2, 1'b0);
    result(16'h00B2);
    result(16'h00C3);
    idle(1, 1'b0);
    result(16'h00D4);
    idle(2, 1'b0);
    result(16'h0111);
    result(16'h0222);
    idle(1, 1'b0);
    result(16'h0333);
    idle(2, 1'b0);

    // reset mid-emit, then a fresh packet
    send(64'h7777_8888_9999_AAAA, 1'b1);
    idle(2, 1'b1);
    reset_mid();
    send(64'h4321_8765_CBA9_0FED, 1'b1);
    idle(6, 1'b1);

    // random traffic on both sides
    for (int i = 0; i < 600; i++) begin
      step($urandom_range(0, 5) == 0, {$urandom, $urandom}, $urandom_range(0, 2) != 0,
           $urandom_range(0, 2) == 0, 16'($urandom), $urandom_range(0, 15) == 0);
    end
    idle(6, 1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/spi_sample_bridge.md
Name: spi_sample_bridge

Overview:
- Sits between the SPI slave's parallel packet side and the 16-bit FIR datapath.
- Unpacks each received 64-bit SPI packet into four 16-bit samples and delivers them to the FIR through a valid/ready handshake.
- Collects four FIR results into a 64-bit response packet, presented atomically as the slave's transmit data for the next SPI transaction.

Parameters:
- SAMPLE_WIDTH, 16, bits per sample and per result.
- SAMPLES_PER_PACKET, 4, samples per SPI packet; must be >= 2.
- PACKET_WIDTH, SAMPLE_WIDTH*SAMPLES_PER_PACKET (64), local derived width; not overridable.

Ports:
- clkIn  input  1  system clock.
- nResetIn  input  1  asynchronous active-low reset.
- packetIn  input  PACKET_WIDTH  received SPI packet, valid only when packetValidIn=1.
- packetValidIn  input  1  one-cycle pulse marking a completed SPI receive.
- sampleOut  output  SAMPLE_WIDTH  sample to FIR.
- sampleValidOut  output  1  sampleOut valid.
- sampleReadyIn  input  1  FIR accepts the sample.
- resultIn  input  SAMPLE_WIDTH  FIR output sample.
- resultValidIn  input  1  resultIn valid (no back-pressure).
- packetOut  output  PACKET_WIDTH  response packet to SPI slave transmit data.
- packetUpdatedOut  output  1  one-cycle pulse when packetOut changes.
- overflowOut  output  1  sticky flag: a packet was dropped.
- clearOverflowIn  input  1  synchronous clear of overflowOut.

Behaviour:
- Reset (nResetIn=0, asynchronous): every output is 0, state IDLE, sample index 0, result count 0, collector 0.
- All other logic is registered on the posedge of clkIn. No combinational path from input to output.
- Ingress FSM, IDLE:
  - A packetValidIn pulse latches packetIn into the shift register, sets index=0 and moves to EMIT.
  - sampleValidOut rises the next cycle, so latency from packetValidIn to the first valid sample is 1 clock.
- Ingress FSM, EMIT:
  - sampleOut is the top SAMPLE_WIDTH bits of the shift register, so samples go out MSB lane first (packetIn[63:48] first).
  - A handshake is sampleValidOut & sampleReadyIn. On a handshake the register shifts left by SAMPLE_WIDTH and the index increments.
  - sampleValidOut and sampleOut hold stable while sampleReadyIn=0.
  - A handshake at index = SAMPLES_PER_PACKET-1 returns the FSM to IDLE, and sampleValidOut drops the next cycle.
- packetValidIn in EMIT before the final handshake: the packet is dropped, overflowOut is set, and the current emission is unaffected.
- packetValidIn in the same cycle as the final handshake: the new packet is latched, the FSM stays in EMIT with index=0, sampleValidOut stays 1, and no overflow is flagged (back-to-back packets allowed).
- clearOverflowIn clears overflowOut. If a set and a clear occur in the same cycle, the set wins.
- Egress:
  - Each resultValidIn shifts resultIn into the collector LSB end and increments the count.
  - On the SAMPLES_PER_PACKET-th result, packetOut loads the full collector including that result, with the first result in the MSBs. The count returns to 0 and packetUpdatedOut pulses 1 cycle.
  - packetOut holds its value between updates. A partial collection never alters packetOut.
- Ingress and egress are independent. Simultaneous events on both sides are handled in the same cycle without interaction.
- Reset mid-operation: the in-flight packet and partial results are discarded and the block returns to its reset values immediately.

Decomposition:
- Shared package (spi_bridge_pkg) holds:
  - the SAMPLE_WIDTH and SAMPLES_PER_PACKET defaults;
  - the ingress state enum {IDLE, EMIT};
  - the PACKET_WIDTH derivation function.
- One sub-module is natural: result_packer, the egress collector, counter, packetOut register and update pulse.
- The ingress FSM stays in the top level.

Test Plan:
- Unpack order: packetIn=0x1111_2222_3333_4444 pulse, sampleReadyIn=1 -> sampleOut 0x1111, 0x2222, 0x3333, 0x4444 on cycles 1–4; sampleValidOut low on cycle 5.
- Back-pressure: drive sampleReadyIn pattern 1,0,0,1,1,0,1 on packet 0xAAAA_BBBB_CCCC_DDDD -> each sample holds while ready=0, exactly 4 handshakes, no duplicates or skips.
- Overflow: second pulse (0x5555_…) arrives at index 1 -> first packet completes intact, 0x5555 never emitted, overflowOut=1. Next, clearOverflowIn and a new drop in the same cycle -> overflowOut stays 1.
- Back-to-back: second packet 0x0001_0002_0003_0004 pulses on the final handshake of the first -> sampleValidOut never drops, 8 samples in order, overflowOut=0.
- Egress: results 0x00A1, 0x00B2, 0x00C3, 0x00D4 with gaps -> packetOut=0x00A1_00B2_00C3_00D4 with one packetUpdatedOut pulse. After 3 further results packetOut is unchanged.
- Reset mid-emit: assert nResetIn low at index 2 -> all outputs 0 asynchronously. After release, a new packet emits from its first lane.
